seg_scan_ctrl: RTL and testbench

- Sequencing controller between `data_gen` (value/point/sign/seg_en source) and the 74HC595 shifter for the 6-digit seven-segment display.
- Once per frame it snapshots the source, converts binary to BCD by sequential double-dabble, then scans the six digits one at a time.
- Each digit's select/segment pattern goes to the shifter over a valid/ready handshake and is held for a fixed dwell time.

---
 rtl/seg_scan_ctrl_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit pattern handshake toward the 74HC595 shifter.
// The master holds sel/seg stable while out_valid waits for out_ready.
interface seg_scan_ctrl_if;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] sel;
  logic [7:0] seg;

  modport master (
    output out_valid,
    output sel,
    output seg,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  sel,
    input  seg,
    output out_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: per-frame snapshot, double-dabble BCD conversion and
// six-digit scan of the seven-segment display through the shifter.
module seg_scan_ctrl #(
  parameter int CNT_DIG_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  seg_scan_ctrl_if.master bus
);

  localparam int CONV_CYCLES = 20;
  localparam int CW = $clog2(CNT_DIG_MAX + 1);
  localparam logic [CW-1:0] DMAX = CW'(CNT_DIG_MAX);
  localparam logic [4:0] CLAST = 5'(CONV_CYCLES - 1);
  localparam logic [19:0] VMAX = 20'd999_999;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CONV,
    SEND,
    DWELL
  } state_t;

  state_t state;
  state_t state_n;

  logic [19:0]   bin_q;
  logic [23:0]   bcd_q;
  logic [23:0]   adj;
  logic [23:0]   bcd_n;
  logic [5:0]    pt_q;
  logic          sg_q;
  logic          en_q;
  logic [4:0]    ccnt;
  logic [CW-1:0] dcnt;
  logic [2:0]    idx;
  logic          valid_q;
  logic [5:0]    sel_q;
  logic [7:0]    seg_q;
  logic          conv_done;
  logic          dwell_done;
  logic          hs;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Returns {sel, seg} for digit idx of a converted frame.
  function automatic logic [13:0] pat(
    input logic [23:0] b,
    input logic [5:0]  pt,
    input logic        sg,
    input logic        en,
    input logic [2:0]  ix
  );
    logic [2:0] m;
    logic [3:0] d;
    logic       p;
    logic [7:0] s;
    m = 3'd0;
    d = 4'd0;
    p = 1'b0;
    for (int i = 1; i < 6; i++) begin
      if (b[4*i +: 4] != 4'd0 || pt[i]) m = 3'(i);
    end
    for (int i = 0; i < 6; i++) begin
      if (3'(i) == ix) begin
        d = b[4*i +: 4];
        p = pt[i];
      end
    end
    if (ix <= m) s = seg7(d);
    else if (sg && m < 3'd5 && ix == m + 3'd1) s = 8'hBF;
    else s = 8'hFF;
    s[7] = ~p;
    if (!en) pat = {6'b0, 8'hFF};
    else pat = {6'b1 << ix, s};
  endfunction

  // Add-3 correction of every BCD nibble before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_n      = {adj[22:0], bin_q[19]};
  assign conv_done  = (state == CONV) && (ccnt == CLAST);
  assign dwell_done = (state == DWELL) && (dcnt == DMAX);
  assign hs         = (state == SEND) && bus.out_ready;

  assign bus.out_valid = valid_q;
  assign bus.sel       = sel_q;
  assign bus.seg       = seg_q;

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = LATCH;
      LATCH: state_n = CONV;
      CONV:  if (conv_done) state_n = SEND;
      SEND:  if (hs) state_n = DWELL;
      DWELL: if (dwell_done)
               state_n = (idx == 3'd5) ? LATCH : SEND;
      default: state_n = IDLE;
    endcase
  end

  // Snapshot, conversion, dwell counting and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      pt_q    <= '0;
      sg_q    <= 1'b0;
      en_q    <= 1'b0;
      ccnt    <= '0;
      dcnt    <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      seg_q   <= 8'hFF;
    end else begin
      unique case (state)
        LATCH: begin
          bin_q <= (data > VMAX) ? VMAX : data;
          bcd_q <= '0;
          pt_q  <= point;
          sg_q  <= sign;
          en_q  <= seg_en;
          ccnt  <= '0;
        end
        CONV: begin
          bin_q <= {bin_q[18:0], 1'b0};
          bcd_q <= bcd_n;
          ccnt  <= ccnt + 5'd1;
          if (conv_done) begin
            idx            <= 3'd0;
            {sel_q, seg_q} <= pat(bcd_n, pt_q, sg_q, en_q, 3'd0);
            valid_q        <= 1'b1;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            dcnt    <= '0;
          end
        end
        DWELL: begin
          if (dcnt == DMAX) begin
            dcnt <= '0;
            if (idx != 3'd5) begin
              idx            <= idx + 3'd1;
              {sel_q, seg_q} <= pat(bcd_q, pt_q, sg_q, en_q,
                                    idx + 3'd1);
              valid_q        <= 1'b1;
            end
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of latency, digit codes, blanking,
// saturation, backpressure and asynchronous reset.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl_if b ();

  seg_scan_ctrl #(.CNT_DIG_MAX(9)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en),
    .bus     (b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic reset_state(input string tag);
    chk({tag, " valid"}, 32'(b.out_valid), 32'd0);
    chk({tag, " sel"}, 32'(b.sel), 32'h00);
    chk({tag, " seg"}, 32'(b.seg), 32'hFF);
  endtask

  // Release reset at a negedge and check the 22-edge startup latency.
  task automatic startup(input string tag, input logic [5:0] sl,
                         input logic [7:0] sg);
    rst = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    chk({tag, " valid@21"}, 32'(b.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid@22"}, 32'(b.out_valid), 32'd1);
    chk({tag, " sel0"}, 32'(b.sel), 32'(sl));
    chk({tag, " seg0"}, 32'(b.seg), 32'(sg));
  endtask

  // Wait for the next out_valid rise and check gap and pattern.
  task automatic digit(input string tag, input int gap,
                       input logic [5:0] sl, input logic [7:0] sg);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (!b.out_valid) n++;
    end while (!b.out_valid && n < 200);
    chk({tag, " gap"}, 32'(n), 32'(gap));
    chk({tag, " sel"}, 32'(b.sel), 32'(sl));
    chk({tag, " seg"}, 32'(b.seg), 32'(sg));
  endtask

  initial begin
    rst    = 1'b1;
    data   = 20'd123456;
    point  = 6'b0;
    sign   = 1'b0;
    seg_en = 1'b1;
    b.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_state("rst0");

    // Frame 1: 123456
    startup("f1", 6'h01, 8'h82);
    digit("f1d1", 10, 6'h02, 8'h92);
    digit("f1d2", 10, 6'h04, 8'h99);
    data  = 20'd5;
    point = 6'b000010;
    sign  = 1'b1;
    digit("f1d3", 10, 6'h08, 8'hB0);
    digit("f1d4", 10, 6'h10, 8'hA4);
    digit("f1d5", 10, 6'h20, 8'hF9);

    // Frame 2: 5 with dp on digit 1 and minus
    digit("f2d0", 31, 6'h01, 8'h92);
    digit("f2d1", 10, 6'h02, 8'h40);
    data  = 20'd1_000_000;
    point = 6'b0;
    sign  = 1'b1;
    digit("f2d2", 10, 6'h04, 8'hBF);
    digit("f2d3", 10, 6'h08, 8'hFF);
    digit("f2d4", 10, 6'h10, 8'hFF);
    digit("f2d5", 10, 6'h20, 8'hFF);

    // Frame 3: saturated 999999, backpressure on digit 2
    digit("f3d0", 31, 6'h01, 8'h90);
    digit("f3d1", 10, 6'h02, 8'h90);
    @(negedge clk);
    b.out_ready = 1'b0;
    digit("f3d2", 9, 6'h04, 8'h90);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("f3 stall%0d", k),
          {17'd0, b.out_valid, b.sel, b.seg},
          {17'd0, 1'b1, 6'h04, 8'h90});
    end
    b.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("f3 stall release", 32'(b.out_valid), 32'd0);
    digit("f3d3", 9, 6'h08, 8'h90);
    seg_en = 1'b0;
    digit("f3d4", 10, 6'h10, 8'h90);
    digit("f3d5", 10, 6'h20, 8'h90);

    // Frame 4: blanked
    digit("f4d0", 31, 6'h00, 8'hFF);
    digit("f4d1", 10, 6'h00, 8'hFF);
    seg_en = 1'b1;
    digit("f4d2", 10, 6'h00, 8'hFF);
    digit("f4d3", 10, 6'h00, 8'hFF);
    digit("f4d4", 10, 6'h00, 8'hFF);
    digit("f4d5", 10, 6'h00, 8'hFF);

    // Frame 5: visible again, then reset during CONV
    digit("f5d0", 31, 6'h01, 8'h90);
    for (int i = 1; i < 6; i++)
      digit($sformatf("f5d%0d", i), 10, 6'(1 << i), 8'h90);
    repeat (20) @(negedge clk);
    chk("pre conv rst sel", 32'(b.sel), 32'h20);
    rst = 1'b1;
    #1;
    reset_state("conv rst");
    @(negedge clk);
    startup("r1", 6'h01, 8'h90);

    // Reset while out_valid is high in SEND
    b.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    reset_state("send rst");
    b.out_ready = 1'b1;
    @(negedge clk);
    startup("r2", 6'h01, 8'h90);
    digit("r2d1", 10, 6'h02, 8'h90);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
